// File: rtl/fifo1to16.sv
`default_nettype none
// ============================================================================
// Module   : fifo1to16
// Purpose  : Packs a byte stream (valid/ready/last) into 16-byte words, with
//            byte 0 in the LSBs, and buffers the words in a small synchronous
//            SRAM FIFO. The read side presents one word per handshake.
// Options  : define FIFO1TO16_FLUSH_EN to let last_i close a short word.
// Revision : 1.0 - initial release
// ============================================================================
module fifo1to16 #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 last_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic [4:0]           count_o,
    output logic [16*WIDTH-1:0]  data_o
);

    localparam int c_DEPTH = 1 << ABITS;
    localparam int c_WSB   = 16*WIDTH - 1;
    localparam int c_EW    = 16*WIDTH + 6;   // {last, count[4:0], data}
    localparam logic [ABITS+1:0] c_READY_LIMIT = (ABITS+2)'(c_DEPTH - 2);

    // Assembler state
    logic [3:0]       r_bidx;
    logic [c_WSB:0]   r_lanes;

    // One-entry pending register between assembler and SRAM
    logic             r_pend_v;
    logic             r_pend_last;
    logic [4:0]       r_pend_cnt;
    logic [c_WSB:0]   r_pend_data;

    // Word FIFO storage and pointers (extra wrap bit)
    logic [c_EW-1:0]  r_mem [c_DEPTH];
    logic [ABITS:0]   r_wptr;
    logic [ABITS:0]   r_rptr;

    // Read pipeline: SRAM read register, then output register
    logic             r_s1_v;
    logic [c_EW-1:0]  r_s1;
    logic             r_ready;
    logic             r_valid;
    logic             r_last;
    logic [4:0]       r_cnt;
    logic [c_WSB:0]   r_data;

    logic             w_accept;
    logic             w_full_word;
    logic             w_close;
    logic [4:0]       w_close_cnt;
    logic             w_close_last;
    logic [c_WSB:0]   w_merged;
    logic [ABITS:0]   w_level;
    logic [ABITS+1:0] w_fill;
    logic             w_out_load;
    logic             w_s1_free;
    logic             w_rd;

    assign w_accept    = valid_i & r_ready;
    assign w_full_word = (r_bidx == 4'd15);

`ifdef FIFO1TO16_FLUSH_EN
    assign w_close      = w_accept & (w_full_word | last_i);
    assign w_close_cnt  = {1'b0, r_bidx} + 5'd1;
    assign w_close_last = last_i;
`else
    assign w_close      = w_accept & w_full_word;
    assign w_close_cnt  = 5'd16;
    assign w_close_last = last_i;
`endif

    // Current lanes with the incoming byte dropped into lane bidx
    always_comb begin
        w_merged = r_lanes;
        for (int k = 0; k < 16; k++) begin
            if (r_bidx == 4'(k)) begin
                w_merged[k*WIDTH +: WIDTH] = data_i;
            end
        end
    end

    assign w_level    = r_wptr - r_rptr;
    assign w_fill     = {1'b0, w_level} + {{(ABITS+1){1'b0}}, r_pend_v};
    assign w_out_load = r_s1_v & (~r_valid | ready_i);
    assign w_s1_free  = ~r_s1_v | w_out_load;
    assign w_rd       = (w_level != '0) & w_s1_free;

    // Assembler: place bytes by lane, clear all lanes when a word closes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bidx  <= 4'd0;
            r_lanes <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_bidx  <= 4'd0;
                r_lanes <= '0;
            end else begin
                r_bidx  <= r_bidx + 4'd1;
                r_lanes <= w_merged;
            end
        end
    end

    // Pending register: holds a closed word for exactly one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_v    <= 1'b0;
            r_pend_last <= 1'b0;
            r_pend_cnt  <= 5'd0;
            r_pend_data <= '0;
        end else begin
            r_pend_v <= w_close;
            if (w_close) begin
                r_pend_last <= w_close_last;
                r_pend_cnt  <= w_close_cnt;
                r_pend_data <= w_merged;
            end
        end
    end

    // SRAM write port; ready_o throttling guarantees a free slot
    always_ff @(posedge clock) begin
        if (!reset && r_pend_v) begin
            r_mem[r_wptr[ABITS-1:0]] <= {r_pend_last, r_pend_cnt, r_pend_data};
        end
    end

    // Write pointer advances as the pending word lands in SRAM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
        end else if (r_pend_v) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Registered SRAM read whenever the read stage is (or is becoming) free
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rptr <= '0;
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_rd) begin
            r_s1   <= r_mem[r_rptr[ABITS-1:0]];
            r_s1_v <= 1'b1;
            r_rptr <= r_rptr + 1'b1;
        end else if (w_out_load) begin
            r_s1_v <= 1'b0;
        end
    end

    // Output register: holds steady under back-pressure
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= 5'd0;
            r_data  <= '0;
        end else if (w_out_load) begin
            r_valid <= 1'b1;
            {r_last, r_cnt, r_data} <= r_s1;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Input ready: leave headroom for a word closed under a stale ready
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_fill <= c_READY_LIMIT);
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign count_o = r_cnt;
    assign data_o  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo1to16.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo1to16
// Purpose  : Self-checking bench for fifo1to16: byte-queue reference model,
//            per-cycle output compare, directed and randomized stimulus.
// Options  : honours FIFO1TO16_FLUSH_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo1to16;

`ifdef FIFO1TO16_FLUSH_EN
    localparam bit c_FLUSH = 1'b1;
`else
    localparam bit c_FLUSH = 1'b0;
`endif

    logic         clock   = 1'b0;
    logic         reset   = 1'b1;
    logic         valid_i = 1'b0;
    logic         last_i  = 1'b0;
    logic [7:0]   data_i  = 8'd0;
    logic         ready_i = 1'b0;
    logic         ready_o;
    logic         valid_o;
    logic         last_o;
    logic [4:0]   count_o;
    logic [127:0] data_o;

    typedef struct packed {
        logic         last;
        logic [4:0]   cnt;
        logic [127:0] data;
    } word_t;

    word_t      exp_q[$];
    word_t      rx_log[$];
    logic [7:0] asm_q[$];
    word_t      m_cur;
    word_t      m_prev;
    word_t      m_exp;
    word_t      m_new;
    bit         prev_stall = 1'b0;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    int lat_close  = -1;
    int lat_valid  = -1;
    int acc        = 0;

    fifo1to16 #(.WIDTH(8), .ABITS(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .last_i  (last_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .count_o (count_o),
        .data_o  (data_o)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream ready driver
    initial begin
        forever begin
            @(posedge clock);
            #2;
            case (ready_mode)
                0:       ready_i = 1'b0;
                1:       ready_i = 1'b1;
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model and per-cycle compare, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                asm_q.delete();
                exp_q.delete();
                prev_stall = 1'b0;
                lat_close  = -1;
                lat_valid  = -1;
            end else begin
                m_cur = {last_o, count_o, data_o};
                if (prev_stall) begin
                    chk("stall_hold_valid", valid_o, 1);
                    chk("stall_hold_word", m_cur, m_prev);
                end
                if (valid_o && lat_valid < 0) lat_valid = cyc;
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: actual=%0h required=none", m_cur);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("out_word", m_cur, m_exp);
                    end
                    rx_log.push_back(m_cur);
                end
                prev_stall = valid_o && !ready_i;
                m_prev     = m_cur;
                if (valid_i && ready_o) begin
                    asm_q.push_back(data_i);
                    if (asm_q.size() == 16 || (c_FLUSH && last_i)) begin
                        m_new.data = '0;
                        for (int i = 0; i < asm_q.size(); i++) m_new.data[i*8 +: 8] = asm_q[i];
                        m_new.cnt  = 5'(asm_q.size());
                        m_new.last = last_i;
                        exp_q.push_back(m_new);
                        asm_q.delete();
                        if (lat_close < 0) lat_close = cyc + 1;
                    end
                end
            end
        end
    end

    // Present one byte until it is accepted (call at posedge+1)
    task automatic send_byte(input logic [7:0] d, input logic l);
        logic a;
        int   n;
        n = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        do begin
            a = ready_o;
            @(posedge clock);
            #1;
            n++;
        end while (!a && n < 2000);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual=ready_low required=accept");
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < max) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_in_time", (n < max), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", ready_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_data", data_o, 0);
        reset      = 1'b0;
        ready_mode = 1;
        @(posedge clock);
        #1;
        chk("ready_after_reset", ready_o, 1);

        // 32 ascending bytes -> two full words, latency 3
        rx_log.delete();
        for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
        wait_drain(200);
        chk("t1_words", rx_log.size(), 2);
        if (rx_log.size() >= 2) begin
            chk("t1_w0_data", rx_log[0].data, 128'h0F0E0D0C0B0A09080706050403020100);
            chk("t1_w1_data", rx_log[1].data, 128'h1F1E1D1C1B1A19181716151413121110);
            chk("t1_w0_cnt", rx_log[0].cnt, 16);
            chk("t1_w1_last", rx_log[1].last, 0);
        end
        chk("t1_latency", lat_valid - lat_close, 3);

        // last_i on the 16th byte -> single full word
        rx_log.delete();
        for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), (i == 15));
        wait_drain(200);
        repeat (20) @(posedge clock);
        #1;
        chk("t3_words", rx_log.size(), 1);
        if (rx_log.size() >= 1) begin
            chk("t3_data", rx_log[0].data, 128'h6F6E6D6C6B6A69686766656463626160);
            chk("t3_cnt", rx_log[0].cnt, 16);
            chk("t3_last", rx_log[0].last, 1);
        end

`ifdef FIFO1TO16_FLUSH_EN
        // Short flushed word and single-byte word
        rx_log.delete();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), (i == 4));
        send_byte(8'h55, 1'b1);
        wait_drain(200);
        chk("fl_words", rx_log.size(), 2);
        if (rx_log.size() >= 2) begin
            chk("fl_data", rx_log[0].data, 128'hA4A3A2A1A0);
            chk("fl_cnt", rx_log[0].cnt, 5);
            chk("fl_last", rx_log[0].last, 1);
            chk("fl1_data", rx_log[1].data, 128'h55);
            chk("fl1_cnt", rx_log[1].cnt, 1);
        end
`endif

        // Reset after 7 bytes discards them
        rx_log.delete();
        for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i), 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("mid_rst_ready", ready_o, 0);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk("mid_rst_no_word", rx_log.size(), 0);
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
        wait_drain(200);
        chk("mid_rst_words", rx_log.size(), 1);
        if (rx_log.size() >= 1) begin
            chk("mid_rst_data", rx_log[0].data, 128'h4F4E4D4C4B4A49484746454443424140);
            chk("mid_rst_cnt", rx_log[0].cnt, 16);
        end

        // Stalled output: input must throttle before overflow
        ready_mode = 0;
        @(posedge clock);
        #1;
        acc = 0;
        valid_i = 1'b1;
        last_i  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            data_i = 8'(acc);
            if (ready_o) acc++;
            @(posedge clock);
            #1;
        end
        valid_i = 1'b0;
        chk("stall_ready_low", ready_o, 0);
        chk("stall_acc_max", (acc <= 18*16 + 15), 1);
        chk("stall_acc_min", (acc >= 17*16), 1);
        ready_mode = 1;
        wait_drain(400);
        repeat (3) @(posedge clock);
        #1;
        chk("stall_ready_back", ready_o, 1);

        // Randomized traffic with both-side stalls
        ready_mode = 2;
        for (int n = 0; n < 4096; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                @(posedge clock);
                #1;
            end
            send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
        end
        ready_mode = 1;
        wait_drain(2000);
        chk("random_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
